tilemap_writer: RTL and testbench

Write-side engine for the background tilemap: accepts tile-update commands and stores 16-bit tile numbers into the packed tilemap memory that the background layer reads, two tiles per 32-bit word. Supports single-tile writes and a whole-map fill (used for screen clear). It sits between the CPU/MMIO command path and the tilemap RAM write port, using the same word-address packing the background layer reads back.

---
 rtl/tilemap_writer_if.sv | 28 ++
 rtl/tilemap_writer.sv | 119 +++++++++++
 tb/tb_tilemap_writer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tilemap_writer_if.sv
// Command and memory-write signal bundle for tilemap_writer.
// The slave modport is the engine side; master is the CPU/memory side.
interface tilemap_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_fill;
  logic [6:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [15:0] cmd_tile;
  logic [29:0] mem_address;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_fill, cmd_x, cmd_y, cmd_tile, mem_ack,
    input  cmd_ready, mem_address, mem_data, mem_be, mem_we, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_fill, cmd_x, cmd_y, cmd_tile, mem_ack,
    output cmd_ready, mem_address, mem_data, mem_be, mem_we, busy, done, err
  );
endinterface

// File: rtl/tilemap_writer.sv
// Tilemap write engine: single-tile writes and whole-map fill, two tiles per word.
// Optional macro TILEMAP_WRITER_BOUNDS_CHECK_EN rejects out-of-range single writes via err.
module tilemap_writer #(
  parameter int          MAP_W     = 80,
  parameter int          MAP_H     = 60,
  parameter logic [29:0] BASE_ADDR = 30'd0
) (
  input  logic              clk,
  input  logic              rst,
  tilemap_writer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  localparam int          WORDS     = MAP_W * MAP_H / 2;
  localparam logic [11:0] LAST_WORD = 12'(WORDS - 1);

  state_t      r_state;
  logic [11:0] r_cnt;
  logic [29:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_be;
  logic        r_we;
  logic        r_busy;
  logic        r_done;

  logic [12:0] w_idx;
  logic        w_accept;
  logic        w_oob;

  // Index arithmetic wraps at 13 bits; bit 0 picks the half-word.
  assign w_idx    = 13'(bus.cmd_y) * 13'(MAP_W) + 13'(bus.cmd_x);
  assign w_accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready   = (r_state == IDLE) && !rst;
  assign bus.mem_address = r_addr;
  assign bus.mem_data    = r_data;
  assign bus.mem_be      = r_be;
  assign bus.mem_we      = r_we;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

`ifdef TILEMAP_WRITER_BOUNDS_CHECK_EN
  logic r_err;

  assign w_oob   = !bus.cmd_fill &&
                   ((32'(bus.cmd_x) >= 32'(MAP_W)) || (32'(bus.cmd_y) >= 32'(MAP_H)));
  assign bus.err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_accept && w_oob;
  end
`else
  assign w_oob   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 12'd0;
      r_addr  <= 30'd0;
      r_data  <= 32'd0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && !w_oob) begin
            r_data <= {bus.cmd_tile, bus.cmd_tile};
            r_we   <= 1'b1;
            r_busy <= 1'b1;
            if (bus.cmd_fill) begin
              r_state <= FILL;
              r_cnt   <= 12'd0;
              r_addr  <= BASE_ADDR;
              r_be    <= 4'b1111;
            end else begin
              r_state <= WRITE;
              r_addr  <= BASE_ADDR + 30'(w_idx[12:1]);
              r_be    <= w_idx[0] ? 4'b0011 : 4'b1100;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            if (r_cnt == LAST_WORD) begin
              r_state <= IDLE;
              r_we    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt  <= r_cnt + 12'd1;
              r_addr <= r_addr + 30'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tilemap_writer.sv
// Randomized and directed bench for tilemap_writer against a queue-based write model.
module tb_tilemap_writer;
  localparam int          MAP_W = 80;
  localparam int          MAP_H = 60;
  localparam int          WORDS = MAP_W * MAP_H / 2;
  localparam logic [29:0] BASE  = 30'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tilemap_writer_if bus();

  tilemap_writer #(.MAP_W(MAP_W), .MAP_H(MAP_H), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a command becomes a list of expected words; each ack retires one.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t m_q[$];
  bit  m_active = 1'b0;
  bit  m_done   = 1'b0;
  bit  m_err    = 1'b0;

  task automatic model_accept();
    logic [31:0] d;
    int          i;
    bit          oob;
    d = {bus.cmd_tile, bus.cmd_tile};
    if (bus.cmd_fill) begin
      for (int n = 0; n < WORDS; n++) m_q.push_back('{a: BASE + 30'(n), d: d, be: 4'b1111});
      m_active = 1'b1;
    end else begin
      i   = (int'(bus.cmd_y) * MAP_W + int'(bus.cmd_x)) % 8192;
      oob = 1'b0;
`ifdef TILEMAP_WRITER_BOUNDS_CHECK_EN
      oob = (int'(bus.cmd_x) >= MAP_W) || (int'(bus.cmd_y) >= MAP_H);
`endif
      if (oob) m_err = 1'b1;
      else begin
        m_q.push_back('{a: BASE + 30'(i / 2), d: d, be: (i % 2 == 1) ? 4'b0011 : 4'b1100});
        m_active = 1'b1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_active) begin
        if (bus.mem_ack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (bus.cmd_valid) begin
        model_accept();
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters for directed checks.
  int we_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_active));
      chk("busy",      32'(bus.busy),      32'(m_active));
      chk("done",      32'(bus.done),      32'(m_done));
      chk("err",       32'(bus.err),       32'(m_err));
      chk("mem_we",    32'(bus.mem_we),    32'(m_active));
      if (m_active && m_q.size() > 0) begin
        chk("mem_address", 32'(bus.mem_address), 32'(m_q[0].a));
        chk("mem_data",    bus.mem_data,         m_q[0].d);
        chk("mem_be",      32'(bus.mem_be),      32'(m_q[0].be));
      end
      if (bus.mem_we) we_cnt++;
      if (bus.done)   done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic fill, input logic [6:0] x, input logic [5:0] y,
                      input logic [15:0] tile);
    bus.cmd_fill  = fill;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_tile  = tile;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.cmd_ready && !bus.busy) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_fill  = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_tile  = '0;
    bus.mem_ack   = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_address",   32'(bus.mem_address), 32'd0);
    chk("rst_data",      bus.mem_data,       32'd0);
    chk("rst_be",        32'(bus.mem_be),    32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    tick();

    // Single write (0,0) with ack already high
    bus.mem_ack = 1'b1;
    send(1'b0, 7'd0, 6'd0, 16'h1234);
    @(negedge clk);
    chk("w00_we",   32'(bus.mem_we), 32'd1);
    chk("w00_addr", 32'(bus.mem_address), 32'h100);
    chk("w00_data", bus.mem_data, 32'h12341234);
    chk("w00_be",   32'(bus.mem_be), 32'b1100);
    tick();
    @(negedge clk);
    chk("w00_done",  32'(bus.done), 32'd1);
    chk("w00_ready", 32'(bus.cmd_ready), 32'd1);
    chk("w00_busy",  32'(bus.busy), 32'd0);
    tick();

    // Single write (3,1): i = 83, odd half
    send(1'b0, 7'd3, 6'd1, 16'hBEEF);
    @(negedge clk);
    chk("w31_addr", 32'(bus.mem_address), 32'h129);
    chk("w31_be",   32'(bus.mem_be), 32'b0011);
    chk("w31_data", bus.mem_data, 32'hBEEFBEEF);
    wait_idle();
    tick();

    // Out-of-range column
    send(1'b0, 7'd80, 6'd0, 16'h5555);
    @(negedge clk);
`ifdef TILEMAP_WRITER_BOUNDS_CHECK_EN
    chk("oob_err",   32'(bus.err), 32'd1);
    chk("oob_we",    32'(bus.mem_we), 32'd0);
    chk("oob_ready", 32'(bus.cmd_ready), 32'd1);
`else
    chk("oob_addr", 32'(bus.mem_address), 32'h128);
    chk("oob_be",   32'(bus.mem_be), 32'b1100);
    chk("oob_err",  32'(bus.err), 32'd0);
`endif
    wait_idle();
    tick();

    // Backpressure: ack low for three cycles
    we_cnt = 0; done_cnt = 0;
    bus.mem_ack = 1'b0;
    send(1'b0, 7'd5, 6'd2, 16'hAAAA);
    repeat (3) tick();
    bus.mem_ack = 1'b1;
    wait_idle();
    tick();
    chk("bp_we_cycles", 32'(we_cnt), 32'd4);
    chk("bp_done_cnt",  32'(done_cnt), 32'd1);

    // Full fill with ack held high
    we_cnt = 0; done_cnt = 0;
    send(1'b1, 7'd0, 6'd0, 16'h0007);
    wait_idle();
    tick();
    chk("fill_words",    32'(we_cnt), 32'd2400);
    chk("fill_done_cnt", 32'(done_cnt), 32'd1);

    // Randomized single writes with random ack backpressure
    for (int c = 0; c < 3000; c++) begin
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_fill  = 1'b0;
      bus.cmd_x     = 7'($urandom_range(0, 127));
      bus.cmd_y     = 6'($urandom_range(0, 63));
      bus.cmd_tile  = 16'($urandom);
      bus.mem_ack   = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.mem_ack   = 1'b1;
    wait_idle();
    tick();

    // Fill under random backpressure
    send(1'b1, 7'd0, 6'd0, 16'($urandom));
    n = 0;
    while (bus.busy && n < 20000) begin
      bus.mem_ack = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (n >= 20000) chk("rfill_timeout", 32'(bus.busy), 32'd0);
    bus.mem_ack = 1'b1;
    tick();

    // Reset in the middle of a fill
    done_cnt = 0;
    send(1'b1, 7'd0, 6'd0, 16'h00C3);
    n = 0;
    while (bus.mem_address != BASE + 30'd500 && n < 5000) begin
      tick();
      n++;
    end
    chk("abort_reached_500", 32'(bus.mem_address), 32'(BASE + 30'd500));
    rst = 1'b1;
    #1;
    chk("abort_we",    32'(bus.mem_we), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd0);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1 chk("abort_ready_release", 32'(bus.cmd_ready), 32'd1);
    bus.mem_ack = 1'b0;
    send(1'b1, 7'd0, 6'd0, 16'h0F0F);
    @(negedge clk);
    chk("refill_addr", 32'(bus.mem_address), 32'(BASE));
    chk("refill_we",   32'(bus.mem_we), 32'd1);
    tick();
    bus.mem_ack = 1'b1;
    wait_idle();
    tick();
    chk("refill_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
